dmem_bus_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_tmo_cnt.sv | 27 ++
 rtl/dmem_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Imported by the controller top and its timeout counter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned BEAT_INC = 4;

endpackage

// File: rtl/dmem_tmo_cnt.sv
// Per-beat timeout counter: counts unacknowledged beat cycles.
// expired flags the cycle in which the count would reach TMO_CYC.
module dmem_tmo_cnt #(
  parameter int unsigned TMO_CYC = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = inc && (cnt == 8'(TMO_CYC - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: splits CPU requests into one or two
// 32-bit acked beats and reports done / busy / timeout to control.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TMO_CYC = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic              dword,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              m_cs,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ack
);

  state_t            state;
  logic              we_r;
  logic              dword_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_hi_r;

  logic in_beat;
  logic beat_ack;
  logic tmo_inc;
  logic tmo_clr;
  logic tmo_exp;

  // A beat cycle is one where the memory actually sees a select.
  assign in_beat  = m_cs && ((state == BEAT0) || (state == BEAT1));
  assign beat_ack = in_beat && m_ack;
  assign tmo_inc  = in_beat && !m_ack;
  assign tmo_clr  = beat_ack || tmo_exp || (state == IDLE);

  dmem_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_exp)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      dword_r    <= 1'b0;
      addr_r     <= '0;
      wdata_hi_r <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      m_cs       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_r       <= we;
            dword_r    <= dword;
            addr_r     <= addr;
            wdata_hi_r <= wdata[63:32];
            if (!we && !dword) begin
              rdata[63:32] <= '0;
            end
            busy    <= 1'b1;
            m_cs    <= 1'b1;
            m_we    <= we;
            m_addr  <= addr;
            m_wdata <= wdata[31:0];
            state   <= BEAT0;
          end
        end
        BEAT0: begin
          if (beat_ack) begin
            if (!we_r) begin
              rdata[31:0] <= m_rdata;
            end
            m_cs  <= 1'b0;
            m_we  <= 1'b0;
            state <= dword_r ? BEAT1 : FIN;
          end else if (tmo_exp) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            m_cs  <= 1'b0;
            m_we  <= 1'b0;
            state <= IDLE;
          end
        end
        BEAT1: begin
          // First BEAT1 cycle is the deselect gap; select rises after it.
          if (!m_cs) begin
            m_cs    <= 1'b1;
            m_we    <= we_r;
            m_addr  <= addr_r + ADDR_W'(BEAT_INC);
            m_wdata <= wdata_hi_r;
          end else if (beat_ack) begin
            if (!we_r) begin
              rdata[63:32] <= m_rdata;
            end
            m_cs  <= 1'b0;
            m_we  <= 1'b0;
            state <= FIN;
          end else if (tmo_exp) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            m_cs  <= 1'b0;
            m_we  <= 1'b0;
            state <= IDLE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed and random transfers
// compared against a cycle-arithmetic reference model.
module tb_dmem_bus_ctrl;

  localparam int TMO = 15;
  localparam int NOACK = 99;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        dword = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        m_cs;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] mdl_rdata = '0;

  always #5 Clk = ~Clk;

  dmem_bus_ctrl #(
    .ADDR_W  (32),
    .TMO_CYC (TMO)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (req),
    .we      (we),
    .dword   (dword),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .m_cs    (m_cs),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issues one request and plays a memory with per-beat ack latency
  // lat (ack on cycle lat+1 of the beat; lat >= TMO means never).
  task automatic run_txn(input logic t_we, input logic t_dword,
                         input logic [31:0] t_addr,
                         input logic [63:0] t_wdata,
                         input int lat0, input int lat1,
                         input bit hold);
    int lat[2];
    int s[2];
    int nb_exp;
    int tob;
    bit to;
    int exp_done;
    int exp_err;
    int end_cyc;
    logic [31:0] d[2];
    int beats;
    int bcyc;
    int done_cyc;
    int err_cyc;
    int n_pulse;
    int busy_bad;
    int start_cyc[2];
    logic [31:0] ob_addr[2];
    logic [31:0] ob_wdata[2];
    logic ob_we[2];
    logic prev_cs;
    logic [31:0] ea;

    lat[0] = lat0;
    lat[1] = lat1;
    d[0] = $urandom;
    d[1] = $urandom;
    nb_exp = t_dword ? 2 : 1;
    to = 1'b0;
    tob = 0;
    s[0] = 1;
    s[1] = s[0] + lat0 + 2;
    for (int b = 0; b < 2; b++) begin
      if (b < nb_exp && !to && lat[b] >= TMO) begin
        to = 1'b1;
        tob = b;
      end
    end
    if (to) nb_exp = tob + 1;
    exp_done = to ? 0 : s[nb_exp-1] + lat[nb_exp-1] + 2;
    exp_err = to ? s[tob] + TMO : 0;
    end_cyc = to ? exp_err : exp_done;

    if (!t_we) begin
      if (!t_dword) mdl_rdata[63:32] = '0;
      if (!(to && tob == 0)) mdl_rdata[31:0] = d[0];
      if (t_dword && !to) mdl_rdata[63:32] = d[1];
    end

    @(negedge Clk);
    req = 1'b1;
    we = t_we;
    dword = t_dword;
    addr = t_addr;
    wdata = t_wdata;
    @(posedge Clk);
    beats = 0;
    bcyc = 0;
    done_cyc = 0;
    err_cyc = 0;
    n_pulse = 0;
    busy_bad = 0;
    prev_cs = 1'b0;
    start_cyc[0] = 0;
    start_cyc[1] = 0;
    ob_addr[0] = '0;
    ob_addr[1] = '0;
    ob_wdata[0] = '0;
    ob_wdata[1] = '0;
    ob_we[0] = 1'b0;
    ob_we[1] = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge Clk);
      if (!hold) req = 1'b0;
      m_ack = 1'b0;
      if (done) begin
        n_pulse++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (err) begin
        n_pulse++;
        if (err_cyc == 0) err_cyc = cyc;
      end
      if (m_cs) begin
        if (!prev_cs) begin
          if (beats < 2) begin
            start_cyc[beats] = cyc;
            ob_addr[beats] = m_addr;
            ob_wdata[beats] = m_wdata;
            ob_we[beats] = m_we;
          end
          beats++;
          bcyc = 0;
        end
        bcyc++;
        if (beats <= 2 && bcyc == lat[beats-1] + 1) begin
          m_ack = 1'b1;
          m_rdata = d[beats-1];
        end
      end else if (!busy) begin
        m_ack = 1'($urandom % 2);
        m_rdata = $urandom;
      end
      if (busy !== (cyc < end_cyc)) busy_bad++;
      prev_cs = m_cs;
      if (cyc >= end_cyc + (hold ? 0 : 1)) break;
    end
    m_ack = 1'b0;

    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("err_cycle", 64'(err_cyc), 64'(exp_err));
    chk("pulse_count", 64'(n_pulse), 64'd1);
    chk("beat_count", 64'(beats), 64'(nb_exp));
    for (int b = 0; b < 2; b++) begin
      if (b < nb_exp) begin
        ea = t_addr + 32'(4 * b);
        chk("beat_start", 64'(start_cyc[b]), 64'(s[b]));
        chk("beat_addr", 64'(ob_addr[b]), 64'(ea));
        chk("beat_we", 64'(ob_we[b]), 64'(t_we));
        if (t_we) begin
          chk("beat_wdata", 64'(ob_wdata[b]),
              64'(b == 0 ? t_wdata[31:0] : t_wdata[63:32]));
        end
      end
    end
    chk("busy_profile", 64'(busy_bad), 64'd0);
    chk("rdata", rdata, mdl_rdata);
  endtask

  initial begin
    int quiet;
    logic r_we;
    logic r_dw;

    repeat (2) @(negedge Clk);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_ctl", 64'({done, err, busy, m_cs, m_we}), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    run_txn(1'b0, 1'b0, 32'h100, 64'd0, 0, 0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h200, 64'h11223344_55667788, 2, 2, 1'b0);
    run_txn(1'b0, 1'b1, 32'hFFFF_FFFC, 64'd0, 1, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h300, 64'd0, NOACK, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h304, 64'd0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h400, 64'd0, TMO - 1, NOACK, 1'b0);
    run_txn(1'b1, 1'b1, 32'h500, 64'hAAAA_BBBB_CCCC_DDDD, 0, NOACK, 1'b0);
    run_txn(1'b0, 1'b0, 32'h600, 64'd0, TMO - 1, 0, 1'b0);

    // req held through FIN: second transfer starts the cycle after done.
    run_txn(1'b1, 1'b0, 32'h700, 64'h0123_4567_89AB_CDEF, 1, 0, 1'b1);
    @(negedge Clk);
    req = 1'b0;
    chk("hold_second_cs", 64'(m_cs), 64'd1);
    chk("hold_second_addr", 64'(m_addr), 64'h700);
    m_ack = 1'b1;
    @(negedge Clk);
    m_ack = 1'b0;
    @(negedge Clk);
    chk("hold_second_done", 64'(done), 64'd1);

    // Reset in the middle of beat1 of a 64-bit read.
    @(negedge Clk);
    req = 1'b1;
    we = 1'b0;
    dword = 1'b1;
    addr = 32'h800;
    @(negedge Clk);
    req = 1'b0;
    m_ack = 1'b1;
    m_rdata = 32'h5555_AAAA;
    @(negedge Clk);
    m_ack = 1'b0;
    @(negedge Clk);
    chk("pre_rst_cs", 64'(m_cs), 64'd1);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_ctl", 64'({done, err, busy, m_cs, m_we}), 64'd0);
    chk("async_rst_rdata", rdata, 64'd0);
    chk("async_rst_m_addr", 64'(m_addr), 64'd0);
    mdl_rdata = '0;
    @(negedge Clk);
    Reset = 1'b1;
    quiet = 0;
    repeat (6) begin
      @(negedge Clk);
      if (done || err || busy) quiet++;
    end
    chk("post_rst_quiet", 64'(quiet), 64'd0);
    run_txn(1'b0, 1'b0, 32'h900, 64'd0, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      r_we = 1'($urandom % 2);
      r_dw = 1'($urandom % 2);
      run_txn(r_we, r_dw, $urandom, {$urandom, $urandom},
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
